// File: rtl/alu_seq.sv
// alu_seq: registered execute-stage ALU. It has an iterative shift-add
// multiplier and an internal N/Z/C/V status register.
//
// Ports:
//   clk         clock, rising edge
//   rst         asynchronous active-low reset
//   in_valid    operation presented
//   in_ready    block can accept (low while a multiply is in flight)
//   exe_cmd     4-bit operation code
//   input_a     operand A
//   input_b     operand B
//   s_en        update status register with this operation's flags
//   out_valid   one-cycle strobe per completed operation
//   result      registered result, held until the next completion
//   status_out  registered {N,Z,C,V}
//
// state  | meaning
// S_IDLE | nothing completing, ready for a command
// S_MUL  | shift-add multiply iterating, input stalled
// S_DONE | result/status hold a fresh completion, ready for a command
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       exe_cmd,
  input  logic [WIDTH-1:0] input_a,
  input  logic [WIDTH-1:0] input_b,
  input  logic             s_en,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       status_out
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;
  localparam logic [3:0] CMD_MUL = 4'b1010;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             s_en_q, s_en_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       status_q, status_d;

  logic             accept;
  logic [WIDTH-1:0] b_op;
  logic             cin;
  logic             is_arith;
  logic             valid_cmd;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] alu_r;
  logic             alu_v;
  logic [WIDTH-1:0] acc_step;

  assign in_ready   = (state_q != S_MUL);
  assign out_valid  = (state_q == S_DONE);
  assign result     = result_q;
  assign status_out = status_q;
  assign accept     = in_valid && in_ready;

  // Single-cycle datapath. Subtraction reuses the adder as A + ~B + cin,
  // so C comes out as NOT-borrow.
  always_comb begin
    b_op      = input_b;
    cin       = 1'b0;
    is_arith  = 1'b0;
    valid_cmd = 1'b1;
    alu_r     = '0;
    sum       = '0;
    case (exe_cmd)
      CMD_MOV: alu_r = input_b;
      CMD_MVN: alu_r = ~input_b;
      CMD_ADD: is_arith = 1'b1;
      CMD_ADC: begin
        is_arith = 1'b1;
        cin      = status_q[1];
      end
      CMD_SUB: begin
        is_arith = 1'b1;
        b_op     = ~input_b;
        cin      = 1'b1;
      end
      CMD_SBC: begin
        is_arith = 1'b1;
        b_op     = ~input_b;
        cin      = status_q[1];
      end
      CMD_AND: alu_r = input_a & input_b;
      CMD_ORR: alu_r = input_a | input_b;
      CMD_EOR: alu_r = input_a ^ input_b;
      CMD_MUL: alu_r = '0;
      default: valid_cmd = 1'b0;
    endcase
    sum = {1'b0, input_a} + {1'b0, b_op} + {{WIDTH{1'b0}}, cin};
    if (is_arith) begin
      alu_r = sum[WIDTH-1:0];
    end
  end

  assign alu_v    = (input_a[WIDTH-1] == b_op[WIDTH-1]) &&
                    (alu_r[WIDTH-1] != input_a[WIDTH-1]);
  assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    s_en_d   = s_en_q;
    result_d = result_q;
    status_d = status_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          if (exe_cmd == CMD_MUL) begin
            state_d  = S_MUL;
            mcand_d  = input_a;
            mplier_d = input_b;
            acc_d    = '0;
            cnt_d    = CW'(WIDTH);
            s_en_d   = s_en;
          end else begin
            state_d  = S_DONE;
            result_d = alu_r;
            if (s_en && valid_cmd) begin
              status_d[3] = alu_r[WIDTH-1];
              status_d[2] = (alu_r == '0);
              if (is_arith) begin
                status_d[1] = sum[WIDTH];
                status_d[0] = alu_v;
              end
            end
          end
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end
      S_MUL: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CW'(1);
        // Flags come from the freshly summed accumulator, not acc_q.
        if (cnt_q == CW'(1)) begin
          state_d  = S_DONE;
          result_d = acc_step;
          if (s_en_q) begin
            status_d[3] = acc_step[WIDTH-1];
            status_d[2] = (acc_step == '0);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      s_en_q   <= 1'b0;
      result_q <= '0;
      status_q <= 4'b0000;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      s_en_q   <= s_en_d;
      result_q <= result_d;
      status_q <= status_d;
    end
  end

endmodule
